mesh_drain: RTL and testbench

//  Downstream stage of the MAC mesh. On a capture pulse, snapshots all MESH_X*MESH_Y signed OUT_BIT accumulators.

---
 rtl/mesh_pkg.sv | 40 ++++
 rtl/mesh_requant.sv | 66 ++++++
 rtl/mesh_drain.sv | 161 ++++++++++++++++
 tb/tb_mesh_drain.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mesh_pkg.sv
// -----------------------------------------------------------------------------
// mesh_pkg
//   Shared definitions for the mesh drain stage:
//     - state_t        : drain FSM state encoding (IDLE=0, DRAIN=1)
//     - calc_n         : number of mesh elements per capture (MESH_X*MESH_Y)
//     - calc_idx_w     : width of the element index ($clog2(N), at least 1)
//     - q_max / q_min  : saturation bounds of a signed Q_BIT result
//     - DEF_*          : default parameter values used by the top level
// -----------------------------------------------------------------------------
package mesh_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam int DEF_OUT_BIT = 20;
  localparam int DEF_MESH_X  = 4;
  localparam int DEF_MESH_Y  = 4;
  localparam int DEF_Q_BIT   = 8;
  localparam int DEF_SHIFT_W = 5;

  function automatic int calc_n(input int mesh_x, input int mesh_y);
    return mesh_x * mesh_y;
  endfunction

  // A single-element mesh still needs a one-bit index port.
  function automatic int calc_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int q_max(input int q_bit);
    return (1 << (q_bit - 1)) - 1;
  endfunction

  function automatic int q_min(input int q_bit);
    return -(1 << (q_bit - 1));
  endfunction

endpackage

// File: rtl/mesh_requant.sv
// -----------------------------------------------------------------------------
// mesh_requant
//   Purely combinational requantizer: signed OUT_BIT accumulator -> signed
//   Q_BIT element. Arithmetic right shift by sh with round-half-up (ties go
//   toward +inf), then saturation to the Q_BIT signed range.
//
//   Build option: define MESH_DRAIN_RELU_EN to clamp negative saturated
//   results to 0 (fused ReLU). Without it, signed values pass unchanged.
//
// Ports
//   x   in   OUT_BIT   signed accumulator value
//   sh  in   SHIFT_W   shift amount, already limited to OUT_BIT-1
//   q   out  Q_BIT     requantized signed result
// -----------------------------------------------------------------------------
module mesh_requant
  import mesh_pkg::*;
#(
  parameter int OUT_BIT = DEF_OUT_BIT,
  parameter int Q_BIT   = DEF_Q_BIT,
  parameter int SHIFT_W = DEF_SHIFT_W
) (
  input  logic signed [OUT_BIT-1:0] x,
  input  logic        [SHIFT_W-1:0] sh,
  output logic signed [Q_BIT-1:0]   q
);

  // One guard bit: with sh <= OUT_BIT-1 the rounding constant is at most
  // 2^(OUT_BIT-2), so x + half can never overflow OUT_BIT+1 bits.
  localparam int W = OUT_BIT + 1;

  localparam logic signed [W-1:0] Q_HI = W'(q_max(Q_BIT));
  localparam logic signed [W-1:0] Q_LO = W'(q_min(Q_BIT));

  logic signed [W-1:0]     x_ext;
  logic signed [W-1:0]     half;
  logic signed [W-1:0]     sum;
  logic signed [W-1:0]     r;
  logic signed [Q_BIT-1:0] sat;

  assign x_ext = {x[OUT_BIT-1], x};

  always_comb begin
    half = '0;
    if (sh != '0) begin
      half = W'(1) << (sh - SHIFT_W'(1));
    end
    // Adding half then flooring via >>> gives round-half-up for both signs.
    sum = x_ext + half;
    r   = sum >>> sh;

    if (r > Q_HI) begin
      sat = Q_HI[Q_BIT-1:0];
    end else if (r < Q_LO) begin
      sat = Q_LO[Q_BIT-1:0];
    end else begin
      sat = r[Q_BIT-1:0];
    end

`ifdef MESH_DRAIN_RELU_EN
    q = sat[Q_BIT-1] ? '0 : sat;
`else
    q = sat;
`endif
  end

endmodule

// File: rtl/mesh_drain.sv
// -----------------------------------------------------------------------------
// mesh_drain
//   Downstream stage of the MAC mesh. A capture pulse (accepted only in IDLE)
//   snapshots all N = MESH_X*MESH_Y signed accumulators together with the
//   shift amount. The snapshot is then streamed out one requantized element
//   per beat over a valid/ready interface, index 0 first, last flagged.
//
//   Build option: MESH_DRAIN_RELU_EN (see mesh_requant) enables a fused ReLU;
//   the handshake and latency are identical in both builds.
//
// Ports
//   clk            in   1              rising-edge clock
//   rst_n          in   1              asynchronous active-low reset
//   capture        in   1              request to snapshot data_in / shift
//   capture_ready  out  1              high only in IDLE
//   data_in        in   N*OUT_BIT      element i at [(i+1)*OUT_BIT-1 : i*OUT_BIT]
//   shift          in   SHIFT_W        right-shift amount, sampled at capture
//   out_valid      out  1              out_data/out_idx/out_last are valid
//   out_ready      in   1              consumer accepts the current beat
//   out_data       out  Q_BIT          requantized element (0 when idle)
//   out_idx        out  IDX_W          element index 0..N-1
//   out_last       out  1              high with element N-1
// -----------------------------------------------------------------------------
module mesh_drain
  import mesh_pkg::*;
#(
  parameter int OUT_BIT = DEF_OUT_BIT,
  parameter int MESH_X  = DEF_MESH_X,
  parameter int MESH_Y  = DEF_MESH_Y,
  parameter int Q_BIT   = DEF_Q_BIT,
  parameter int SHIFT_W = DEF_SHIFT_W
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       capture,
  output logic                                       capture_ready,
  input  logic [MESH_X*MESH_Y*OUT_BIT-1:0]           data_in,
  input  logic [SHIFT_W-1:0]                         shift,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [Q_BIT-1:0]                           out_data,
  output logic [calc_idx_w(MESH_X*MESH_Y)-1:0]       out_idx,
  output logic                                       out_last
);

  localparam int N     = calc_n(MESH_X, MESH_Y);
  localparam int IDX_W = calc_idx_w(N);

  // Largest meaningful shift; anything above it is clamped at capture time.
  localparam logic [SHIFT_W-1:0] SH_MAX   = SHIFT_W'(OUT_BIT - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(N - 1);

  state_t                    state_reg, state_next;
  logic [IDX_W-1:0]          idx_reg, idx_next;
  logic [SHIFT_W-1:0]        sh_reg, sh_next;

  // Snapshot buffer: written as a whole on capture, never reset.
  logic signed [OUT_BIT-1:0] buf_reg [N];
  logic signed [OUT_BIT-1:0] data_elem [N];

  logic                      capture_accept;
  logic [SHIFT_W-1:0]        sh_clamped;
  logic                      at_last;
  logic signed [OUT_BIT-1:0] elem_sel;
  logic signed [Q_BIT-1:0]   q_elem;

  // Unpack the flat accumulator bus into per-element views.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
      assign data_elem[gi] = data_in[gi*OUT_BIT +: OUT_BIT];
    end
  endgenerate

  assign sh_clamped     = (shift > SH_MAX) ? SH_MAX : shift;
  assign capture_accept = capture & capture_ready;
  assign at_last        = (idx_reg == IDX_LAST);

  // ---------------------------------------------------------------------------
  // FSM state and drain counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      sh_reg    <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      sh_reg    <= sh_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    sh_next       = sh_reg;
    capture_ready = 1'b0;
    out_valid     = 1'b0;

    case (state_reg)
      IDLE: begin
        capture_ready = 1'b1;
        if (capture) begin
          sh_next    = sh_clamped;
          idx_next   = '0;
          state_next = DRAIN;
        end
      end

      DRAIN: begin
        // capture is deliberately not looked at here: a pulse mid-drain is dropped.
        out_valid = 1'b1;
        if (out_ready) begin
          if (at_last) begin
            idx_next   = '0;
            state_next = IDLE;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Snapshot buffer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (capture_accept) begin
      for (int i = 0; i < N; i++) begin
        buf_reg[i] <= data_elem[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output path: select the current element and requantize it. The selected
  // element and shift are registers that only change on a beat, so the
  // outputs hold stable under backpressure without extra staging.
  // ---------------------------------------------------------------------------
  assign elem_sel = buf_reg[idx_reg];

  mesh_requant #(
    .OUT_BIT (OUT_BIT),
    .Q_BIT   (Q_BIT),
    .SHIFT_W (SHIFT_W)
  ) u_requant (
    .x  (elem_sel),
    .sh (sh_reg),
    .q  (q_elem)
  );

  assign out_data = out_valid ? q_elem : '0;
  assign out_idx  = idx_reg;
  assign out_last = out_valid & at_last;

endmodule

// File: tb/tb_mesh_drain.sv
module tb_mesh_drain;

  localparam int OUT_BIT = 20;
  localparam int MESH_X  = 4;
  localparam int MESH_Y  = 4;
  localparam int Q_BIT   = 8;
  localparam int SHIFT_W = 5;
  localparam int N       = 16;
  localparam int IDX_W   = 4;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   capture = 1'b0;
  logic                   capture_ready;
  logic [N*OUT_BIT-1:0]   data_in = '0;
  logic [SHIFT_W-1:0]     shift = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [Q_BIT-1:0]       out_data;
  logic [IDX_W-1:0]       out_idx;
  logic                   out_last;

  int errors = 0;
  int checks = 0;

  // Observations gathered by the drain task
  int obs_data [64];
  int obs_idx  [64];
  int obs_last [64];
  int st_data  [64];
  int st_idx   [64];
  int st_last  [64];
  int n_beats, n_cycles, n_stall, cr_high;

  // Snapshot the model believes the DUT holds
  int snap [N];
  int snap_shift;

  always #5 clk = ~clk;

  mesh_drain #(
    .OUT_BIT (OUT_BIT),
    .MESH_X  (MESH_X),
    .MESH_Y  (MESH_Y),
    .Q_BIT   (Q_BIT),
    .SHIFT_W (SHIFT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .capture       (capture),
    .capture_ready (capture_ready),
    .data_in       (data_in),
    .shift         (shift),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_idx       (out_idx),
    .out_last      (out_last)
  );

  // Reference: round(x / 2^sh) with halves toward +inf, then saturate.
  function automatic int ref_q(input int x, input int shift_in);
    int     sh;
    longint num, d, q;
    sh = (shift_in > OUT_BIT - 1) ? OUT_BIT - 1 : shift_in;
    if (sh == 0) begin
      q = x;
    end else begin
      d   = longint'(1) << sh;
      num = longint'(x) + d / 2;
      q   = num / d;
      if ((num % d) != 0 && num < 0) q = q - 1;
    end
    if (q > 127)  q = 127;
    if (q < -128) q = -128;
`ifdef MESH_DRAIN_RELU_EN
    if (q < 0) q = 0;
`endif
    return int'(q);
  endfunction

  function automatic int rand_val();
    logic [OUT_BIT-1:0] r;
    r = OUT_BIT'($urandom);
    return int'($signed(r));
  endfunction

  // Called at a negedge; drives a one-cycle capture and returns at the next negedge.
  task automatic do_capture(input int vals [N], input int sh);
    for (int i = 0; i < N; i++) begin
      data_in[i*OUT_BIT +: OUT_BIT] = OUT_BIT'(vals[i]);
      snap[i] = vals[i];
    end
    shift      = SHIFT_W'(sh);
    snap_shift = sh;
    capture    = 1'b1;
    @(negedge clk);
    capture = 1'b0;
    for (int i = 0; i < N; i++) data_in[i*OUT_BIT +: OUT_BIT] = OUT_BIT'($urandom);
    shift = SHIFT_W'($urandom);
  endtask

  // Drains one snapshot, recording beats and stall-cycle outputs. Called at a negedge.
  task automatic drain(input int stall_at, input int stall_len, input int cap_at, input bit rand_ready);
    bit done;
    bit cap_done;
    n_beats = 0; n_cycles = 0; n_stall = 0; cr_high = 0;
    done = 1'b0; cap_done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      capture = 1'b0;
      if (out_valid) begin
        n_cycles++;
        if (capture_ready) cr_high++;
        if (cap_at >= 0 && int'(out_idx) == cap_at && !cap_done) begin
          capture  = 1'b1;
          cap_done = 1'b1;
          for (int i = 0; i < N; i++) data_in[i*OUT_BIT +: OUT_BIT] = OUT_BIT'($urandom);
          shift = SHIFT_W'($urandom);
        end
        if ((int'(out_idx) == stall_at && n_stall < stall_len) ||
            (rand_ready && $urandom_range(0, 3) == 0)) begin
          out_ready = 1'b0;
          if (n_stall < 64) begin
            st_data[n_stall] = int'($signed(out_data));
            st_idx[n_stall]  = int'(out_idx);
            st_last[n_stall] = int'(out_last);
          end
          n_stall++;
        end else begin
          out_ready = 1'b1;
          if (n_beats < 64) begin
            obs_data[n_beats] = int'($signed(out_data));
            obs_idx[n_beats]  = int'(out_idx);
            obs_last[n_beats] = int'(out_last);
          end
          n_beats++;
          if (out_last) done = 1'b1;
        end
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    capture = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
    checks++; if (capture_ready !== 1'b1) begin errors++; $display("FAIL reset capture_ready: got %b expected 1", capture_ready); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset out_data: got %h expected 0", out_data); end
    checks++; if (out_idx !== '0) begin errors++; $display("FAIL reset out_idx: got %0d expected 0", out_idx); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset out_last: got %b expected 0", out_last); end
    rst_n = 1'b1;
    @(negedge clk);
    $display("test_reset done: errors=%0d", errors);
  endtask

  task automatic test_ramp();
    int vals [N];
    int exp;
    for (int i = 0; i < N; i++) vals[i] = 256 * i;
    do_capture(vals, 4);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ramp latency: out_valid got %b expected 1", out_valid); end
    drain(-1, 0, -1, 1'b0);
    checks++; if (n_beats !== N) begin errors++; $display("FAIL ramp beats: got %0d expected %0d", n_beats, N); end
    checks++; if (n_cycles !== N) begin errors++; $display("FAIL ramp cycles: got %0d expected %0d", n_cycles, N); end
    for (int k = 0; k < N; k++) begin
      exp = ref_q(snap[k], snap_shift);
      checks++; if (obs_idx[k] !== k) begin errors++; $display("FAIL ramp idx beat %0d: got %0d expected %0d", k, obs_idx[k], k); end
      checks++; if (obs_data[k] !== exp) begin errors++; $display("FAIL ramp data beat %0d: got %0d expected %0d", k, obs_data[k], exp); end
      checks++; if (obs_last[k] !== int'(k == N - 1)) begin errors++; $display("FAIL ramp last beat %0d: got %0d expected %0d", k, obs_last[k], int'(k == N - 1)); end
    end
    $display("test_ramp done: beats=%0d cycles=%0d errors=%0d", n_beats, n_cycles, errors);
  endtask

  // Each entry: four fixed leading values and a shift; remaining elements random.
  task automatic test_rounding_saturation();
    int vals [N];
    int exp;
    int lead [6][4];
    int shs  [6];
    lead[0] = '{24, 23, -24, -25};           shs[0] = 4;
    lead[1] = '{100, -100, 1, -1};           shs[1] = 0;
    lead[2] = '{524287, -524288, 262144, -262145}; shs[2] = 31;
    lead[3] = '{5000, -5000, 2040, 2039};    shs[3] = 4;
    lead[4] = '{524287, -524288, 127, -129}; shs[4] = 0;
    lead[5] = '{-8, 8, -9, 7};               shs[5] = 4;
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < N; i++) vals[i] = (i < 4) ? lead[t][i] : rand_val();
      do_capture(vals, shs[t]);
      drain(-1, 0, -1, 1'b0);
      checks++; if (n_beats !== N) begin errors++; $display("FAIL round set %0d beats: got %0d expected %0d", t, n_beats, N); end
      for (int k = 0; k < N; k++) begin
        exp = ref_q(snap[k], snap_shift);
        checks++; if (obs_data[k] !== exp) begin errors++; $display("FAIL round set %0d beat %0d: x=%0d shift=%0d got %0d expected %0d", t, k, snap[k], snap_shift, obs_data[k], exp); end
      end
      $display("test_rounding set %0d shift=%0d: lead out %0d %0d %0d %0d", t, shs[t], obs_data[0], obs_data[1], obs_data[2], obs_data[3]);
    end
  endtask

  task automatic test_backpressure();
    int vals [N];
    int exp;
    for (int i = 0; i < N; i++) vals[i] = rand_val() / 8;
    do_capture(vals, 4);
    drain(5, 3, -1, 1'b0);
    checks++; if (n_cycles !== 19) begin errors++; $display("FAIL bp cycles: got %0d expected 19", n_cycles); end
    checks++; if (n_stall !== 3) begin errors++; $display("FAIL bp stalls: got %0d expected 3", n_stall); end
    for (int s = 0; s < 3; s++) begin
      checks++; if (st_idx[s] !== 5) begin errors++; $display("FAIL bp idx held %0d: got %0d expected 5", s, st_idx[s]); end
      checks++; if (st_data[s] !== obs_data[5]) begin errors++; $display("FAIL bp data held %0d: got %0d expected %0d", s, st_data[s], obs_data[5]); end
      checks++; if (st_last[s] !== 0) begin errors++; $display("FAIL bp last held %0d: got %0d expected 0", s, st_last[s]); end
    end
    for (int k = 0; k < N; k++) begin
      exp = ref_q(snap[k], snap_shift);
      checks++; if (obs_data[k] !== exp || obs_idx[k] !== k) begin errors++; $display("FAIL bp beat %0d: got idx %0d data %0d expected idx %0d data %0d", k, obs_idx[k], obs_data[k], k, exp); end
    end
    $display("test_backpressure done: cycles=%0d errors=%0d", n_cycles, errors);
  endtask

  task automatic test_capture_ignored();
    int vals [N];
    int exp;
    for (int i = 0; i < N; i++) vals[i] = rand_val();
    do_capture(vals, 3);
    drain(-1, 0, 3, 1'b0);
    checks++; if (n_beats !== N) begin errors++; $display("FAIL capign beats: got %0d expected %0d", n_beats, N); end
    checks++; if (cr_high !== 0) begin errors++; $display("FAIL capign capture_ready in drain: got %0d cycles high expected 0", cr_high); end
    for (int k = 0; k < N; k++) begin
      exp = ref_q(snap[k], snap_shift);
      checks++; if (obs_data[k] !== exp) begin errors++; $display("FAIL capign beat %0d: got %0d expected %0d", k, obs_data[k], exp); end
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL capign restart: out_valid got %b expected 0", out_valid); end
    $display("test_capture_ignored done: errors=%0d", errors);
  endtask

  task automatic test_async_reset();
    int  vals [N];
    int  exp;
    bit  seen;
    for (int i = 0; i < N; i++) vals[i] = rand_val();
    do_capture(vals, 6);
    out_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (out_valid && out_idx == 4'd7) seen = 1'b1;
      else @(negedge clk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL arst reach idx7: got 0 expected 1"); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL arst out_data: got %h expected 0", out_data); end
    checks++; if (out_idx !== '0 || out_last !== 1'b0) begin errors++; $display("FAIL arst idx/last: got %0d/%b expected 0/0", out_idx, out_last); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (capture_ready !== 1'b1) begin errors++; $display("FAIL arst capture_ready: got %b expected 1", capture_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst idle after release: out_valid got %b expected 0", out_valid); end
    for (int i = 0; i < N; i++) vals[i] = rand_val();
    do_capture(vals, 2);
    drain(-1, 0, -1, 1'b0);
    checks++; if (n_beats !== N) begin errors++; $display("FAIL arst redrain beats: got %0d expected %0d", n_beats, N); end
    for (int k = 0; k < N; k++) begin
      exp = ref_q(snap[k], snap_shift);
      checks++; if (obs_idx[k] !== k || obs_data[k] !== exp) begin errors++; $display("FAIL arst redrain beat %0d: got idx %0d data %0d expected idx %0d data %0d", k, obs_idx[k], obs_data[k], k, exp); end
    end
    $display("test_async_reset done: errors=%0d", errors);
  endtask

  // Random data/shift/ready, each capture issued on the bubble cycle after the previous drain.
  task automatic test_back_to_back();
    int vals [N];
    int exp;
    for (int t = 0; t < 6; t++) begin
      checks++; if (capture_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b idle %0d: got ready %b valid %b expected 1 0", t, capture_ready, out_valid); end
      for (int i = 0; i < N; i++) vals[i] = rand_val();
      do_capture(vals, int'($urandom_range(0, 31)));
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b latency %0d: out_valid got %b expected 1", t, out_valid); end
      drain(-1, 0, -1, 1'b1);
      checks++; if (n_beats !== N) begin errors++; $display("FAIL b2b beats %0d: got %0d expected %0d", t, n_beats, N); end
      for (int k = 0; k < N; k++) begin
        exp = ref_q(snap[k], snap_shift);
        checks++; if (obs_idx[k] !== k || obs_data[k] !== exp || obs_last[k] !== int'(k == N - 1)) begin
          errors++;
          $display("FAIL b2b run %0d beat %0d: got idx %0d data %0d last %0d expected idx %0d data %0d last %0d",
                   t, k, obs_idx[k], obs_data[k], obs_last[k], k, exp, int'(k == N - 1));
        end
      end
      $display("test_back_to_back run %0d shift=%0d cycles=%0d stalls=%0d", t, snap_shift, n_cycles, n_stall);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_rounding_saturation();
    test_backpressure();
    test_capture_ignored();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
